// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   DEF_DATA_WIDTH  : default memory data width in bits
//   DEF_ADDR_WIDTH  : default memory address width in bits
package sram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        DONE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selector.
//   req[1:0]    : pending requests
//   last_grant  : index of the requester served most recently
//   grant       : index of the requester to serve next (meaningful when req != 0)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto one asynchronous-control single-port SRAM.
//   clk, rst                 : clock and synchronous active-high reset
//   req, req_we              : per-requester request and write enable
//   req_addr0/1, req_wdata0/1: per-requester address and write data
//   ack                      : one-cycle completion pulse per requester
//   rdata                    : read data, valid while the read's ack is high
//   mem_address, mem_data    : SRAM address and bidirectional data bus
//   mem_cs, mem_we, mem_oe   : SRAM chip select, write enable, output enable
// All outputs come straight from flops. ack is registered out of DONE, so it
// shows in the IDLE cycle after DONE; IDLE holds off granting in that cycle so a
// requester that keeps req high afterwards is seen as a fresh request.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    arb_state_t            state_r;
    arb_state_t            state_s;
    logic                  start_s;
    logic                  grant_s;
    logic                  gnt_idx_r;
    logic                  last_grant_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            ack_r;
    logic                  cs_r;
    logic                  we_r;
    logic                  oe_r;
    logic                  drive_r;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign ack         = ack_r;
    assign rdata       = rdata_r;
    assign mem_address = addr_r;
    assign mem_cs      = cs_r;
    assign mem_we      = we_r;
    assign mem_oe      = oe_r;
    // Only the WR state owns the bus; everywhere else the SRAM may drive it.
    assign mem_data    = drive_r ? wdata_r : {DATA_WIDTH{1'bz}};

    // Next-state logic; a grant is held off while the previous ack is showing.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if ((req != 2'b00) && (ack_r == 2'b00)) begin
                    start_s = 1'b1;
                    state_s = req_we[grant_s] ? WR : RD1;
                end else begin
                    state_s = IDLE;
                end
            end
            WR:      state_s = DONE;
            RD1:     state_s = RD2;
            RD2:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and SRAM control flops, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cs_r    <= 1'b0;
            we_r    <= 1'b0;
            oe_r    <= 1'b0;
            drive_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cs_r    <= (state_s == WR) || (state_s == RD1) || (state_s == RD2);
            we_r    <= (state_s == WR);
            oe_r    <= (state_s == RD1) || (state_s == RD2);
            drive_r <= (state_s == WR);
        end
    end

    // Latch the granted requester's index, address and write data at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx_r <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
        end else if (start_s) begin
            gnt_idx_r <= grant_s;
            addr_r    <= grant_s ? req_addr1 : req_addr0;
            wdata_r   <= grant_s ? req_wdata1 : req_wdata0;
        end else begin
            gnt_idx_r <= gnt_idx_r;
            addr_r    <= addr_r;
            wdata_r   <= wdata_r;
        end
    end

    // Completion: ack pulse and round-robin history from DONE, read capture at the end of RD2.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r        <= 2'b00;
            last_grant_r <= 1'b1;
            rdata_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            if (state_r == DONE) begin
                ack_r        <= gnt_idx_r ? 2'b10 : 2'b01;
                last_grant_r <= gnt_idx_r;
            end else begin
                ack_r        <= 2'b00;
                last_grant_r <= last_grant_r;
            end
            if (state_r == RD2) begin
                rdata_r <= mem_data;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// single-port SRAM (cs/we/oe, registered read) on the shared data bus.
// The bus is a pulled-up net, so any cycle where neither side drives it reads
// as all ones; that is how an illegal arbiter drive becomes visible.
module tb_sram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_address;
    tri1  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    int tests    = 0;
    int fails    = 0;
    int bus_viol = 0;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_we      (req_we),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_wdata0  (req_wdata0),
        .req_wdata1  (req_wdata1),
        .ack         (ack),
        .rdata       (rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe)
    );

    always #5 clk = ~clk;

    // SRAM model
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] sram_q;
    logic          sram_drv;

    // Write on cs&we; registered read on cs&oe, driven onto the bus the next cycle.
    always @(posedge clk) begin
        if (rst) sram_drv <= 1'b0;
        else     sram_drv <= mem_cs && mem_oe && !mem_we;
        if (mem_cs && mem_we) sram_mem[mem_address] <= mem_data;
        if (mem_cs && mem_oe && !mem_we) sram_q <= sram_mem[mem_address];
    end

    assign mem_data = sram_drv ? sram_q : {DW{1'bz}};

    // Bus monitor: outside WR, with the SRAM silent, the bus must float to the pull-up.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (!sram_drv && !(mem_cs === 1'b1 && mem_we === 1'b1) && mem_data !== 16'hFFFF)
                bus_viol = bus_viol + 1;
            if (mem_we === 1'b1 && mem_oe === 1'b1)
                bus_viol = bus_viol + 1;
        end
    end

    // One access: raise req, wait (bounded) for ack, drop req in the ack cycle.
    task automatic do_access(input int r, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        int n;
        lat = -1;
        rd  = 16'h0000;
        @(negedge clk);
        req_we[r] = wr;
        if (r == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
        req[r] = 1'b1;
        n = 0;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[r] === 1'b1) begin
                lat    = n;
                rd     = rdata;
                req[r] = 1'b0;
            end
        end
        req[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; req_we = 2'b00;
        req_addr0 = 10'h000; req_addr1 = 10'h000; req_wdata0 = 16'h0000; req_wdata1 = 16'h0000;
        repeat (3) @(negedge clk);
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b want 00", ack); end
        tests++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL reset_cs: got %b want 0", mem_cs); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
        tests++; if (mem_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", mem_oe); end
        tests++; if (mem_address !== 10'h000) begin fails++; $display("FAIL reset_addr: got %h want 000", mem_address); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        tests++; if (mem_data !== 16'hFFFF) begin fails++; $display("FAIL reset_bus_released: got %h want FFFF", mem_data); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        logic [DW-1:0] rd;
        @(negedge clk);
        req_we[0] = 1'b1; req_addr0 = 10'h003; req_wdata0 = 16'hA5A5; req[0] = 1'b1;
        @(negedge clk); // WR
        tests++; if (mem_cs !== 1'b1) begin fails++; $display("FAIL wr_cs: got %b want 1", mem_cs); end
        tests++; if (mem_we !== 1'b1 || mem_oe !== 1'b0) begin fails++; $display("FAIL wr_we_oe: got we=%b oe=%b want we=1 oe=0", mem_we, mem_oe); end
        tests++; if (mem_data !== 16'hA5A5) begin fails++; $display("FAIL wr_bus_data: got %h want A5A5", mem_data); end
        tests++; if (mem_address !== 10'h003) begin fails++; $display("FAIL wr_addr: got %h want 003", mem_address); end
        @(negedge clk); // DONE
        tests++; if (mem_cs !== 1'b0 || ack !== 2'b00) begin fails++; $display("FAIL done_cs_ack: got cs=%b ack=%b want cs=0 ack=00", mem_cs, ack); end
        tests++; if (mem_address !== 10'h003) begin fails++; $display("FAIL done_addr_hold: got %h want 003", mem_address); end
        @(negedge clk); // ack cycle, 3 after grant
        tests++; if (ack !== 2'b01) begin fails++; $display("FAIL wr_ack_cycle3: got %b want 01", ack); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL wr_rdata_unchanged: got %h want 0000", rdata); end
        req[0] = 1'b0;
        do_access(0, 1'b0, 10'h003, 16'h0000, lat, rd);
        tests++; if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d want 4", lat); end
        tests++; if (rd !== 16'hA5A5) begin fails++; $display("FAIL rd_data: got %h want A5A5", rd); end
        @(negedge clk);
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL ack_one_cycle: got %b want 00", ack); end
    endtask

    task automatic test_simultaneous();
        int k;
        int n;
        int order [4];
        int when  [4];
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_we = 2'b11;
        req_addr0 = 10'h010; req_wdata0 = 16'h1111;
        req_addr1 = 10'h011; req_wdata1 = 16'h2222;
        req = 2'b11;
        k = 0; n = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack !== 2'b00) begin
                order[k] = (ack === 2'b10) ? 1 : 0;
                when[k]  = n;
                k++;
            end
        end
        req = 2'b00;
        tests++; if (k !== 4) begin fails++; $display("FAIL rr_ack_count: got %0d want 4", k); end
        tests++; if (k == 4 && (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1)) begin
            fails++; $display("FAIL rr_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]); end
        tests++; if (k == 4 && (when[0] !== 3 || when[1] !== 7)) begin
            fails++; $display("FAIL rr_timing: got %0d,%0d want 3,7", when[0], when[1]); end
    endtask

    task automatic test_read_bus();
        int lat;
        int v0;
        logic [DW-1:0] rd;
        v0 = bus_viol;
        do_access(1, 1'b0, 10'h010, 16'h0000, lat, rd);
        tests++; if (lat !== 4 || rd !== 16'h1111) begin fails++; $display("FAIL rd_r1_010: got lat=%0d data=%h want lat=4 data=1111", lat, rd); end
        do_access(0, 1'b0, 10'h011, 16'h0000, lat, rd);
        tests++; if (lat !== 4 || rd !== 16'h2222) begin fails++; $display("FAIL rd_r0_011: got lat=%0d data=%h want lat=4 data=2222", lat, rd); end
        do_access(1, 1'b1, 10'h012, 16'h5A5A, lat, rd);
        tests++; if (lat !== 3 || rd !== 16'h2222) begin fails++; $display("FAIL wr_keeps_rdata: got lat=%0d rdata=%h want lat=3 rdata=2222", lat, rd); end
        tests++; if (bus_viol !== v0) begin fails++; $display("FAIL bus_release: got %0d violations want 0", bus_viol - v0); end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        @(negedge clk);
        req_we[0] = 1'b0; req_addr0 = 10'h003; req[0] = 1'b1;
        @(negedge clk); // RD1
        tests++; if (mem_oe !== 1'b1 || mem_cs !== 1'b1) begin fails++; $display("FAIL rd1_ctrl: got cs=%b oe=%b want 1 1", mem_cs, mem_oe); end
        @(negedge clk); // RD2
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        tests++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL rstmid_cs: got %b want 0", mem_cs); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL rstmid_rdata: got %h want 0000", rdata); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack !== 2'b00) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_ack: got ack seen=%b want 0", seen); end
    endtask

    task automatic test_early_drop();
        int n;
        int lat;
        logic [DW-1:0] rd;
        @(negedge clk);
        req_we[1] = 1'b0; req_addr1 = 10'h003; req_wdata1 = 16'h0000; req[1] = 1'b1;
        @(negedge clk); // RD1
        req[1] = 1'b0;
        n = 1; lat = -1; rd = 16'h0000;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[1] === 1'b1) begin lat = n; rd = rdata; end
        end
        tests++; if (lat !== 4) begin fails++; $display("FAIL drop_ack: got latency %0d want 4", lat); end
        tests++; if (rd !== 16'hA5A5) begin fails++; $display("FAIL drop_rdata: got %h want A5A5", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_read_bus();
        test_reset_mid_read();
        test_early_drop();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
